// File: rtl/mst_stream_gen_pkg.sv
// Shared definitions for the pattern-stream generator: pattern modes, lane FSM states, PRBS31 constants.
package pkg_ft601_ctrl_defines;

   typedef enum logic [1:0] {
      MODE_INC   = 2'd0,
      MODE_DEC   = 2'd1,
      MODE_PRBS  = 2'd2,
      MODE_WALK1 = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // x^31 + x^28 + 1: feedback taken from register bits 30 and 27
   localparam logic [30:0] PRBS31_SEED   = 31'h1;
   localparam int          PRBS31_TAP_HI = 30;
   localparam int          PRBS31_TAP_LO = 27;

endpackage

// File: rtl/mst_stream_gen_if.sv
// Per-channel valid/ready stream bundle: generator drives valid/data/last, sink drives ready.
interface mst_stream_gen_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32
) ();
   logic [NUM_CH-1:0]             ch_valid;
   logic [NUM_CH-1:0]             ch_ready;
   logic [NUM_CH-1:0]             ch_last;
   logic [NUM_CH-1:0][DATA_W-1:0] ch_data;

   modport master (output ch_valid, output ch_data, output ch_last, input ch_ready);
   modport slave  (input ch_valid, input ch_data, input ch_last, output ch_ready);
endinterface

// File: rtl/mst_stream_gen_lane.sv
// One stream channel: IDLE/STREAM FSM, beat/packet counters and pattern state; valid one cycle after en,
// outputs held while ready=0. MST_STREAM_GEN_PRBS_EN adds the PRBS31 generator for mode 2.
module mst_stream_lane
   import pkg_ft601_ctrl_defines::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus16,
   input  logic              en_i,
   input  logic [1:0]        mode_i,
   input  logic [LEN_W-1:0]  pkt_len_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o,
   output logic [LEN_W-1:0]  pkt_cnt_o
);
   localparam int HALF_W = DATA_W / 2;

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   mode_e             mode_in;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [LEN_W-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic [LEN_W-1:0]  len_eff;
   logic [DATA_W-1:0] pat_q, pat_d;
   logic [DATA_W-1:0] word;
   logic              last;

`ifdef MST_STREAM_GEN_PRBS_EN
   logic [30:0] lfsr_q, lfsr_d;
   logic [31:0] prbs_word;
   assign prbs_word = {1'b0, lfsr_q};
`endif

   function automatic logic [DATA_W-1:0] seed_of(input mode_e m);
      case (m)
         MODE_DEC:   seed_of = '1;
         MODE_WALK1: seed_of = DATA_W'(1);
         default:    seed_of = '0;
      endcase
   endfunction

   // In 16-bit bus mode only the low half is meaningful, so rotation wraps at HALF_W
   function automatic logic [DATA_W-1:0] step_of(input mode_e m, input logic [DATA_W-1:0] p,
                                                 input logic b16);
      case (m)
         MODE_DEC:   step_of = p - DATA_W'(1);
         MODE_WALK1: step_of = b16 ? {p[DATA_W-1:HALF_W], p[HALF_W-2:0], p[HALF_W-1]}
                                   : {p[DATA_W-2:0], p[DATA_W-1]};
         default:    step_of = p + DATA_W'(1);
      endcase
   endfunction

   assign mode_in = mode_e'(mode_i);
   assign len_eff = (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;
   assign last    = (state_q == ST_STREAM) && (beat_q == len_q - LEN_W'(1));

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      len_d     = len_q;
      beat_d    = beat_q;
      pkt_cnt_d = pkt_cnt_q;
      pat_d     = pat_q;
`ifdef MST_STREAM_GEN_PRBS_EN
      lfsr_d    = lfsr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (en_i) begin
               state_d = ST_STREAM;
               mode_d  = mode_in;
               len_d   = len_eff;
               beat_d  = '0;
               pat_d   = seed_of(mode_in);
`ifdef MST_STREAM_GEN_PRBS_EN
               lfsr_d  = PRBS31_SEED;
`endif
            end
         end
         ST_STREAM: begin
            if (ready_i) begin
               pat_d = step_of(mode_q, pat_q, bus16);
`ifdef MST_STREAM_GEN_PRBS_EN
               lfsr_d = {lfsr_q[29:0], lfsr_q[PRBS31_TAP_HI] ^ lfsr_q[PRBS31_TAP_LO]};
`endif
               if (last) begin
                  beat_d    = '0;
                  pkt_cnt_d = pkt_cnt_q + LEN_W'(1);
                  // en is only looked at here, so a mid-packet drop never truncates
                  if (en_i) begin
                     mode_d = mode_in;
                     len_d  = len_eff;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  beat_d = beat_q + LEN_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_INC;
         len_q     <= LEN_W'(1);
         beat_q    <= '0;
         pkt_cnt_q <= '0;
         pat_q     <= '0;
`ifdef MST_STREAM_GEN_PRBS_EN
         lfsr_q    <= PRBS31_SEED;
`endif
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         pkt_cnt_q <= pkt_cnt_d;
         pat_q     <= pat_d;
`ifdef MST_STREAM_GEN_PRBS_EN
         lfsr_q    <= lfsr_d;
`endif
      end
   end

   always_comb begin
      word = pat_q;
`ifdef MST_STREAM_GEN_PRBS_EN
      if (mode_q == MODE_PRBS) word = prbs_word[DATA_W-1:0];
`endif
      data_o = '1;
      if (state_q == ST_STREAM) data_o = bus16 ? {{HALF_W{1'b1}}, word[HALF_W-1:0]} : word;
   end

   assign valid_o   = (state_q == ST_STREAM);
   assign last_o    = last;
   assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: rtl/mst_stream_gen.sv
// NUM_CH independent pattern-stream generators; valid one cycle after ch_en, data/last held under backpressure.
// Define MST_STREAM_GEN_PRBS_EN to build in PRBS31 for mode 2; otherwise mode 2 behaves as INC.
module mst_stream_gen
   import pkg_ft601_ctrl_defines::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          bus16,
   input  logic [NUM_CH-1:0]             ch_en,
   input  logic [NUM_CH-1:0][1:0]        ch_mode,
   input  logic [NUM_CH-1:0][LEN_W-1:0]  ch_pkt_len,
   output logic [NUM_CH-1:0][LEN_W-1:0]  ch_pkt_cnt,
   mst_stream_gen_if.master              st
);
   logic [NUM_CH-1:0]             valid_w;
   logic [NUM_CH-1:0]             last_w;
   logic [NUM_CH-1:0][DATA_W-1:0] data_w;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      mst_stream_lane #(
         .DATA_W (DATA_W),
         .LEN_W  (LEN_W)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .bus16     (bus16),
         .en_i      (ch_en[i]),
         .mode_i    (ch_mode[i]),
         .pkt_len_i (ch_pkt_len[i]),
         .ready_i   (st.ch_ready[i]),
         .valid_o   (valid_w[i]),
         .data_o    (data_w[i]),
         .last_o    (last_w[i]),
         .pkt_cnt_o (ch_pkt_cnt[i])
      );
   end

   assign st.ch_valid = valid_w;
   assign st.ch_last  = last_w;
   assign st.ch_data  = data_w;

endmodule
